// File: rtl/dac_replay_pkg.sv
// Shared types and constants for the DAC sample-table replay sequencer.
// Used by dac_replay_fifo and dac_replay_sequencer.
package dac_replay_pkg;

   localparam int unsigned DAC_LANES    = 8;
   localparam int unsigned DAC_SAMPLE_W = 16;
   localparam int unsigned DAC_WORD_W   = DAC_LANES * DAC_SAMPLE_W;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } seq_state_e;

endpackage

// File: rtl/dac_replay_fifo.sv
// Show-ahead synchronous FIFO carrying one table word plus its end-of-pass tag.
// Callers never push when full or pop when empty; the sequencer's credit rule ensures this.
module dac_replay_fifo import dac_replay_pkg::*; #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = DAC_WORD_W,
   parameter int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             last_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             last_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width:0]  mem_q [Depth];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= ptr_inc(wptr_q);
         if (pop_i)  rptr_q <= ptr_inc(rptr_q);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push_i) mem_q[wptr_q] <= {last_i, data_i};
   end

   assign {last_o, data_o} = mem_q[rptr_q];
   assign empty_o          = (count_q == '0);
   assign count_o          = count_q;

endmodule

// File: rtl/dac_replay_sequencer.sv
// Replays the DAC sample table from BRAM onto AXIS with start/stop, length and loop count.
// Optional DAC_REPLAY_STALL_MON_EN adds a `stall` output flagging prolonged downstream backpressure.
module dac_replay_sequencer import dac_replay_pkg::*; #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned SAMPLE_W = DAC_SAMPLE_W,
   parameter int unsigned LANES    = DAC_LANES,
   parameter int unsigned RD_LAT   = 2
`ifdef DAC_REPLAY_STALL_MON_EN
   ,
   parameter int unsigned STALL_THRESH = 1024
`endif
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      stop,
   input  logic [ADDR_W:0]           cfg_len,
   input  logic [15:0]               cfg_loops,
   output logic                      rd_en,
   output logic [ADDR_W-1:0]         rd_addr,
   input  logic [SAMPLE_W*LANES-1:0] rd_data,
   output logic [SAMPLE_W*LANES-1:0] m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic                      busy,
   output logic                      done,
   output logic [15:0]               pass_count
`ifdef DAC_REPLAY_STALL_MON_EN
   ,
   output logic                      stall
`endif
);

   localparam int unsigned WordW     = SAMPLE_W * LANES;
   localparam int unsigned FifoDepth = RD_LAT + 2;
   localparam int unsigned CntW      = $clog2(FifoDepth + 1);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [15:0]       loops_q, loops_d;
   logic [15:0]       issued_q, issued_d;
   logic [15:0]       pass_q, pass_d;
   logic              done_q, done_d;
   logic [RD_LAT-1:0] vld_q, tag_q;

   logic [CntW-1:0]   in_flight, fifo_count;
   logic              fifo_empty, fifo_last, credit_ok, at_end, last_pass, issue, beat;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         in_flight = in_flight + CntW'(vld_q[i]);
      end
   end

   // Reads in flight count against FIFO space so backpressure can never overflow it.
   assign credit_ok = (32'(in_flight) + 32'(fifo_count)) < FifoDepth;
   assign at_end    = ({1'b0, addr_q} == len_q - (ADDR_W + 1)'(1));
   assign last_pass = (loops_q != '0) && (issued_q == loops_q - 16'd1);
   assign beat      = m_axis_tvalid & m_axis_tready;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      loops_d  = loops_q;
      issued_d = issued_q;
      pass_d   = pass_q;
      done_d   = 1'b0;
      issue    = 1'b0;

      if (beat && fifo_last && pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;

      case (state_q)
         StIdle: begin
            if (start && cfg_len != '0) begin
               len_d    = cfg_len;
               loops_d  = cfg_loops;
               addr_d   = '0;
               issued_d = '0;
               pass_d   = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            if (stop) begin
               state_d = StDrain;
            end else if (credit_ok) begin
               issue = 1'b1;
               if (at_end) begin
                  addr_d   = '0;
                  issued_d = issued_q + 16'd1;
                  if (last_pass) state_d = StDrain;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         StDrain: begin
            if (in_flight == '0 && fifo_empty) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         len_q    <= '0;
         loops_q  <= '0;
         issued_q <= '0;
         pass_q   <= '0;
         done_q   <= 1'b0;
         vld_q    <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         loops_q  <= loops_d;
         issued_q <= issued_d;
         pass_q   <= pass_d;
         done_q   <= done_d;
         vld_q[0] <= issue;
         tag_q[0] <= issue & at_end;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   dac_replay_fifo #(
      .Depth (FifoDepth),
      .Width (WordW),
      .CntW  (CntW)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (vld_q[RD_LAT-1]),
      .data_i  (rd_data),
      .last_i  (tag_q[RD_LAT-1]),
      .pop_i   (beat),
      .data_o  (m_axis_tdata),
      .last_o  (fifo_last),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rd_en         = issue;
   assign rd_addr       = addr_q;
   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tlast  = fifo_last & m_axis_tvalid;
   assign busy          = (state_q != StIdle);
   assign done          = done_q;
   assign pass_count    = pass_q;

`ifdef DAC_REPLAY_STALL_MON_EN
   localparam int unsigned StallW = $clog2(STALL_THRESH + 1);

   logic [StallW-1:0] stall_cnt_q;
   logic              stalled;

   assign stalled = m_axis_tvalid & ~m_axis_tready;

   always_ff @(posedge clock) begin
      if (reset || !stalled) begin
         stall_cnt_q <= '0;
      end else if (32'(stall_cnt_q) < STALL_THRESH) begin
         stall_cnt_q <= stall_cnt_q + StallW'(1);
      end
   end

   // Counter holds previous stalled cycles; add the current one so stall rises on the THRESH-th.
   assign stall = stalled && ((32'(stall_cnt_q) + 32'd1) >= STALL_THRESH);
`endif

endmodule
